// File: rtl/recarga_pkg.sv
// Package: recarga_pkg
// Shared types and constants for the recharge kiosk controller.
//   estado_t        : controller states (idle, accumulating, delivering, refunding)
//   CRED_W          : width of the credit register
//   CARGA_W         : width of the carrega/troco outputs consumed by the turnstile
//   CRED_MAX_PADRAO : default maximum credit per load
//   TIMEOUT_PADRAO  : default idle cycles in ACUMULA before auto-cancel
package recarga_pkg;

    typedef enum logic [1:0] {
        OCIOSO,
        ACUMULA,
        ENTREGA,
        DEVOLVE
    } estado_t;

    localparam int CRED_W          = 3;
    localparam int CARGA_W         = 2;
    localparam int CRED_MAX_PADRAO = 3;
    localparam int TIMEOUT_PADRAO  = 10;

endpackage

// File: rtl/recarga_cartao_detector_borda.sv
// Module: detector_borda
// Registered rising-edge detector for N level inputs.
//   clk_2  : clock, all updates on posedge
//   reset  : synchronous active-high; loads the history with the current
//            levels so that releasing reset never produces an edge
//   nivel  : input levels
//   borda  : one-cycle pulse per input, one cycle after the level rises
module detector_borda
    import recarga_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk_2,
    input  logic         reset,
    input  logic [N-1:0] nivel,
    output logic [N-1:0] borda
);

    logic [N-1:0] anterior;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            anterior <= nivel;
            borda    <= '0;
        end else begin
            anterior <= nivel;
            borda    <= nivel & ~anterior;
        end
    end

endmodule

// File: rtl/recarga_cartao.sv
// Module: recarga_cartao
// Recharge kiosk controller feeding the turnstile's carrega1/carrega2 inputs.
// Accepts unit coins, then on confirm emits a one-cycle load pulse (1..CRED_MAX)
// to the selected passenger, or returns the credit as change on cancel/timeout.
//   clk_2    : clock, all updates on posedge
//   reset    : synchronous active-high
//   moeda    : coin level (rising edge = one unit)
//   sel      : 0 = passenger 1, 1 = passenger 2, sampled when confirm is acted on
//   confirma : confirm level (rising edge)
//   cancela  : cancel level (rising edge)
//   carrega1 : load value for card 1, nonzero for one cycle
//   carrega2 : load value for card 2, nonzero for one cycle
//   credito  : credit accumulated in the current transaction
//   troco    : change returned, nonzero for one cycle
//   rejeita  : one-cycle pulse when a coin is refused
//   ocupado  : high while delivering or refunding
module recarga_cartao
    import recarga_pkg::*;
#(
    parameter int CRED_MAX = CRED_MAX_PADRAO,
    parameter int TIMEOUT  = TIMEOUT_PADRAO
) (
    input  logic               clk_2,
    input  logic               reset,
    input  logic               moeda,
    input  logic               sel,
    input  logic               confirma,
    input  logic               cancela,
    output logic [CARGA_W-1:0] carrega1,
    output logic [CARGA_W-1:0] carrega2,
    output logic [CRED_W-1:0]  credito,
    output logic [CARGA_W-1:0] troco,
    output logic               rejeita,
    output logic               ocupado
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // Credit is copied into the 2-bit load/change outputs by truncation.
    generate
        if (CRED_MAX < 1 || CRED_MAX > 3) begin : g_cred_max_invalido
            $error("CRED_MAX must be in 1..3 to fit the 2-bit carrega width");
        end
    endgenerate

    logic [2:0] borda;
    logic       moeda_b, confirma_b, cancela_b;

    detector_borda #(.N(3)) u_borda (
        .clk_2 (clk_2),
        .reset (reset),
        .nivel ({cancela, confirma, moeda}),
        .borda (borda)
    );

    assign moeda_b    = borda[0];
    assign confirma_b = borda[1];
    assign cancela_b  = borda[2];

    estado_t              estado, estado_nx;
    logic [CNT_W-1:0]     ocioso_cnt, ocioso_cnt_nx;
    logic [CRED_W-1:0]    credito_nx;
    logic [CARGA_W-1:0]   carrega1_nx, carrega2_nx, troco_nx;
    logic                 rejeita_nx, ocupado_nx;

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        estado_nx     = estado;
        credito_nx    = credito;
        ocioso_cnt_nx = ocioso_cnt;
        carrega1_nx   = '0;
        carrega2_nx   = '0;
        troco_nx      = '0;
        rejeita_nx    = 1'b0;
        ocupado_nx    = 1'b0;

        unique case (estado)
            OCIOSO: begin
                if (moeda_b) begin
                    credito_nx    = CRED_W'(1);
                    ocioso_cnt_nx = '0;
                    estado_nx     = ACUMULA;
                end
            end

            ACUMULA: begin
                if (cancela_b) begin
                    estado_nx  = DEVOLVE;
                    troco_nx   = credito[CARGA_W-1:0];
                    ocupado_nx = 1'b1;
                    rejeita_nx = moeda_b;
                end else if (confirma_b && credito != '0) begin
                    // The load pulse is registered on the same edge that
                    // enters ENTREGA, so sel is captured right here.
                    estado_nx  = ENTREGA;
                    ocupado_nx = 1'b1;
                    rejeita_nx = moeda_b;
                    if (sel) carrega2_nx = credito[CARGA_W-1:0];
                    else     carrega1_nx = credito[CARGA_W-1:0];
                end else if (moeda_b) begin
                    ocioso_cnt_nx = '0;
                    if (credito < CRED_W'(CRED_MAX)) credito_nx = credito + CRED_W'(1);
                    else                            rejeita_nx = 1'b1;
                end else if (confirma_b) begin
                    ocioso_cnt_nx = '0;
                end else if (ocioso_cnt == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th consecutive cycle without an edge.
                    estado_nx  = DEVOLVE;
                    troco_nx   = credito[CARGA_W-1:0];
                    ocupado_nx = 1'b1;
                end else begin
                    ocioso_cnt_nx = ocioso_cnt + CNT_W'(1);
                end
            end

            ENTREGA, DEVOLVE: begin
                // Edges are dropped here; a coin is still acknowledged as refused.
                estado_nx  = OCIOSO;
                credito_nx = '0;
                rejeita_nx = moeda_b;
            end

            default: estado_nx = OCIOSO;
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            estado     <= OCIOSO;
            credito    <= '0;
            ocioso_cnt <= '0;
            carrega1   <= '0;
            carrega2   <= '0;
            troco      <= '0;
            rejeita    <= 1'b0;
            ocupado    <= 1'b0;
        end else begin
            estado     <= estado_nx;
            credito    <= credito_nx;
            ocioso_cnt <= ocioso_cnt_nx;
            carrega1   <= carrega1_nx;
            carrega2   <= carrega2_nx;
            troco      <= troco_nx;
            rejeita    <= rejeita_nx;
            ocupado    <= ocupado_nx;
        end
    end

endmodule

// File: tb/tb_recarga_cartao.sv
// Testbench: tb_recarga_cartao
// Directed table of per-cycle inputs and expected outputs for recarga_cartao,
// plus hand-written sequences for reset release, timeout and reset in ENTREGA.
// Expected output vector layout: {carrega1, carrega2, credito, troco, rejeita, ocupado}.
module tb_recarga_cartao;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic       moeda, sel, confirma, cancela;
    logic [1:0] carrega1, carrega2, troco;
    logic [2:0] credito;
    logic       rejeita, ocupado;

    int n_checks = 0;
    int n_errors = 0;

    recarga_cartao dut (
        .clk_2    (clk_2),
        .reset    (reset),
        .moeda    (moeda),
        .sel      (sel),
        .confirma (confirma),
        .cancela  (cancela),
        .carrega1 (carrega1),
        .carrega2 (carrega2),
        .credito  (credito),
        .troco    (troco),
        .rejeita  (rejeita),
        .ocupado  (ocupado)
    );

    always #5 clk_2 = ~clk_2;

    typedef struct {
        logic        m;
        logic        s;
        logic        cf;
        logic        cn;
        logic [10:0] exp;
        string       name;
    } vec_t;

    vec_t tabela[$];

    function automatic logic [10:0] pack(input logic [1:0] c1, input logic [1:0] c2,
                                         input logic [2:0] cr, input logic [1:0] tr,
                                         input logic rj, input logic oc);
        return {c1, c2, cr, tr, rj, oc};
    endfunction

    function automatic logic [10:0] saidas();
        return {carrega1, carrega2, credito, troco, rejeita, ocupado};
    endfunction

    task automatic add(input logic m, input logic s, input logic cf, input logic cn,
                       input logic [1:0] c1, input logic [1:0] c2, input logic [2:0] cr,
                       input logic [1:0] tr, input logic rj, input logic oc, input string name);
        vec_t v;
        v.m = m; v.s = s; v.cf = cf; v.cn = cn;
        v.exp  = pack(c1, c2, cr, tr, rj, oc);
        v.name = name;
        tabela.push_back(v);
    endtask

    task automatic check(input string name, input logic [10:0] actual, input logic [10:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got c1=%0d c2=%0d cred=%0d troco=%0d rej=%0d ocup=%0d, want c1=%0d c2=%0d cred=%0d troco=%0d rej=%0d ocup=%0d",
                     name, actual[10:9], actual[8:7], actual[6:4], actual[3:2], actual[1], actual[0],
                     expected[10:9], expected[8:7], expected[6:4], expected[3:2], expected[1], expected[0]);
        end
    endtask

    // Drive inputs on the falling edge, then sample just after the rising edge.
    task automatic cyc(input logic m, input logic s, input logic cf, input logic cn);
        @(negedge clk_2);
        moeda = m; sel = s; confirma = cf; cancela = cn;
        @(posedge clk_2);
        #1;
    endtask

    task automatic moedas(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // 2 coins, sel = 1, confirm -> carrega2 = 2
        add(1,0,0,0, 0,0,0,0,0,0, "s1 coin1 hi");
        add(0,0,0,0, 0,0,1,0,0,0, "s1 coin1 lo");
        add(1,0,0,0, 0,0,1,0,0,0, "s1 coin2 hi");
        add(0,0,0,0, 0,0,2,0,0,0, "s1 coin2 lo");
        add(0,1,1,0, 0,0,2,0,0,0, "s1 confirm rise");
        add(0,1,1,0, 0,2,2,0,0,1, "s1 entrega");
        add(0,1,0,0, 0,0,0,0,0,0, "s1 back idle");
        // 4 coins, sel = 0 -> 4th coin refused, carrega1 = 3
        add(1,0,0,0, 0,0,0,0,0,0, "s2 coin1 hi");
        add(0,0,0,0, 0,0,1,0,0,0, "s2 coin1 lo");
        add(1,0,0,0, 0,0,1,0,0,0, "s2 coin2 hi");
        add(0,0,0,0, 0,0,2,0,0,0, "s2 coin2 lo");
        add(1,0,0,0, 0,0,2,0,0,0, "s2 coin3 hi");
        add(0,0,0,0, 0,0,3,0,0,0, "s2 coin3 lo");
        add(1,0,0,0, 0,0,3,0,0,0, "s2 coin4 hi");
        add(0,0,0,0, 0,0,3,0,1,0, "s2 coin4 refused");
        add(0,0,1,0, 0,0,3,0,0,0, "s2 confirm rise");
        add(0,0,1,0, 3,0,3,0,0,1, "s2 entrega");
        add(0,0,0,0, 0,0,0,0,0,0, "s2 back idle");
        // 1 coin, confirm and cancel together -> cancel wins, troco = 1
        add(1,0,0,0, 0,0,0,0,0,0, "s3 coin hi");
        add(0,0,0,0, 0,0,1,0,0,0, "s3 coin lo");
        add(0,0,1,1, 0,0,1,0,0,0, "s3 cf+cn rise");
        add(0,0,1,1, 0,0,1,1,0,1, "s3 devolve");
        add(0,0,0,0, 0,0,0,0,0,0, "s3 back idle");
        // confirm / cancel in OCIOSO are ignored
        add(0,0,1,0, 0,0,0,0,0,0, "s4 idle confirm rise");
        add(0,0,0,0, 0,0,0,0,0,0, "s4 idle confirm seen");
        add(0,0,0,1, 0,0,0,0,0,0, "s4 idle cancel rise");
        add(0,0,0,0, 0,0,0,0,0,0, "s4 idle cancel seen");
        // coin arriving during ENTREGA is refused and starts nothing
        add(1,0,0,0, 0,0,0,0,0,0, "s5 coin hi");
        add(0,0,0,0, 0,0,1,0,0,0, "s5 coin lo");
        add(0,0,1,0, 0,0,1,0,0,0, "s5 confirm rise");
        add(1,0,1,0, 1,0,1,0,0,1, "s5 entrega coin");
        add(0,0,0,0, 0,0,0,0,1,0, "s5 coin refused");
        add(0,0,0,0, 0,0,0,0,0,0, "s5 still idle");
        // coin edge together with confirm edge in ACUMULA is refused
        add(1,1,0,0, 0,0,0,0,0,0, "s6 coin hi");
        add(0,1,0,0, 0,0,1,0,0,0, "s6 coin lo");
        add(1,1,1,0, 0,0,1,0,0,0, "s6 coin+confirm rise");
        add(0,1,1,0, 0,1,1,0,1,1, "s6 entrega + reject");
        add(0,1,0,0, 0,0,0,0,0,0, "s6 back idle");

        // Reset with the coin level already high: no edge on release.
        reset = 1'b1; moeda = 1'b1; sel = 1'b0; confirma = 1'b0; cancela = 1'b0;
        @(posedge clk_2); #1;
        @(posedge clk_2); #1;
        check("reset state", saidas(), pack(0,0,0,0,0,0));
        @(negedge clk_2); reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("no edge on reset release", saidas(), pack(0,0,0,0,0,0));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        foreach (tabela[i]) begin
            cyc(tabela[i].m, tabela[i].s, tabela[i].cf, tabela[i].cn);
            check(tabela[i].name, saidas(), tabela[i].exp);
        end

        // Timeout: 2 coins then 10 idle cycles -> troco = 2 on the 10th.
        moedas(2);
        check("to credit 2", saidas(), pack(0,0,2,0,0,0));
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("to idle %0d", i), saidas(), pack(0,0,2,0,0,0));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("to devolve", saidas(), pack(0,0,2,2,0,1));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("to back idle", saidas(), pack(0,0,0,0,0,0));

        // Reset asserted in the ENTREGA cycle: pulse and credit are lost.
        moedas(3);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("rst entrega", saidas(), pack(3,0,3,0,0,1));
        @(negedge clk_2); reset = 1'b1; confirma = 1'b0;
        @(posedge clk_2); #1;
        check("rst in entrega", saidas(), pack(0,0,0,0,0,0));
        @(negedge clk_2); reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst after release", saidas(), pack(0,0,0,0,0,0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
